// File: rtl/nibbler_pkg.sv
// Shared definitions for the nibbler fetch/sequencer stage and the
// microcode decoder that consumes its opcode/phase/flag outputs.
//   OPC_W   : opcode width (top bits of every program word)
//   phase_t : two-phase sequencer state (fetch / execute)
//   opcode_t: instruction encoding, common to fetch and decoder
package nibbler_pkg;

  localparam int OPC_W = 4;

  typedef enum logic {
    PH_FETCH = 1'b0,
    PH_EXEC  = 1'b1
  } phase_t;

  typedef enum logic [OPC_W-1:0] {
    OP_JC   = 4'd0,
    OP_JNC  = 4'd1,
    OP_CMPI = 4'd2,
    OP_CMPM = 4'd3,
    OP_LIT  = 4'd4,
    OP_IN   = 4'd5,
    OP_LD   = 4'd6,
    OP_ST   = 4'd7,
    OP_JZ   = 4'd8,
    OP_JNZ  = 4'd9,
    OP_ADDI = 4'd10,
    OP_ADDM = 4'd11,
    OP_JMP  = 4'd12,
    OP_OUT  = 4'd13,
    OP_NORI = 4'd14,
    OP_NORM = 4'd15
  } opcode_t;

endpackage : nibbler_pkg

// File: rtl/nibbler_pc.sv
// Program counter register for the nibbler sequencer.
// Ports:
//   clk, reset_n : clock (rising edge), asynchronous active-low reset
//   en           : update window (execute phase with the sequencer running)
//   load         : jump, pc <= load_addr (takes priority over inc)
//   inc          : pc <= pc + 1, wrapping modulo 2^PC_W
//   load_addr    : jump target
//   pc           : current program counter
module nibbler_pc #(
  parameter int PC_W = 12
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            en,
  input  logic            load,
  input  logic            inc,
  input  logic [PC_W-1:0] load_addr,
  output logic [PC_W-1:0] pc
);

  logic [PC_W-1:0] pc_d;
  logic [PC_W-1:0] pc_q;

  always_comb begin
    pc_d = pc_q;
    if (en) begin
      if (load) begin
        pc_d = load_addr;
      end else if (inc) begin
        // Natural overflow of the PC_W-bit add gives the required wrap.
        pc_d = pc_q + {{(PC_W-1){1'b0}}, 1'b1};
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc_q <= '0;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc = pc_q;

endmodule : nibbler_pc

// File: rtl/nibbler_fetch.sv
// Fetch/sequencer stage in front of the microcode decoder. Owns the PC,
// instruction register, fetch/execute phase toggle and the C/Z flags.
// Ports:
//   clk, reset_n        : clock (rising edge), asynchronous active-low reset
//   run                 : 1 = advance, 0 = freeze every register
//   prog_addr/prog_data : combinational program memory read at pc
//   load_pc/inc_pc      : decoder PC strobes, honoured in execute only
//   load_flag/alu_c/z   : decoder flag strobe and ALU results, execute only
//   phase               : 0 = fetch, 1 = execute
//   opcode/operand/address : fields of the instruction register
//   c_flag/z_flag       : registered flags back to the decoder
//   pc                  : current program counter
module nibbler_fetch
  import nibbler_pkg::*;
#(
  parameter int PC_W    = 12,
  parameter int INSTR_W = 16
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               run,
  output logic [PC_W-1:0]    prog_addr,
  input  logic [INSTR_W-1:0] prog_data,
  input  logic               load_pc,
  input  logic               inc_pc,
  input  logic               load_flag,
  input  logic               alu_c,
  input  logic               alu_z,
  output logic               phase,
  output logic [OPC_W-1:0]   opcode,
  output logic [3:0]         operand,
  output logic [PC_W-1:0]    address,
  output logic               c_flag,
  output logic               z_flag,
  output logic [PC_W-1:0]    pc
);

  phase_t             phase_d, phase_q;
  logic [INSTR_W-1:0] ir_d, ir_q;
  logic               c_d, c_q;
  logic               z_d, z_q;
  logic               fetch_en;
  logic               exec_en;

  assign fetch_en = run && (phase_q == PH_FETCH);
  assign exec_en  = run && (phase_q == PH_EXEC);

  // Phase FSM next state plus IR and flag next values. Strobes only matter
  // in execute; the flags feeding a conditional jump are the pre-edge ones.
  always_comb begin
    phase_d = phase_q;
    ir_d    = ir_q;
    c_d     = c_q;
    z_d     = z_q;
    if (run) begin
      phase_d = (phase_q == PH_FETCH) ? PH_EXEC : PH_FETCH;
    end
    if (fetch_en) begin
      ir_d = prog_data;
    end
    if (exec_en && load_flag) begin
      c_d = alu_c;
      z_d = alu_z;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      phase_q <= PH_FETCH;
      ir_q    <= '0;
      c_q     <= 1'b0;
      z_q     <= 1'b0;
    end else begin
      phase_q <= phase_d;
      ir_q    <= ir_d;
      c_q     <= c_d;
      z_q     <= z_d;
    end
  end

  nibbler_pc #(
    .PC_W (PC_W)
  ) u_pc (
    .clk       (clk),
    .reset_n   (reset_n),
    .en        (exec_en),
    .load      (load_pc),
    .inc       (inc_pc),
    .load_addr (ir_q[PC_W-1:0]),
    .pc        (pc)
  );

  assign prog_addr = pc;
  assign phase     = (phase_q == PH_EXEC);
  assign opcode    = ir_q[INSTR_W-1 -: OPC_W];
  assign operand   = ir_q[3:0];
  assign address   = ir_q[PC_W-1:0];
  assign c_flag    = c_q;
  assign z_flag    = z_q;

endmodule : nibbler_fetch

// File: doc/nibbler_fetch.md
Name: nibbler_fetch

Overview:
Fetch/sequencer stage directly upstream of the microcode decoder. It owns the program counter, the instruction register, the two-phase fetch/execute toggle and the C/Z flag register. It feeds the decoder with opcode[3:0], phase and the registered C/Z flags, and applies the decoder's PC and flag strobes on the execute phase.

Parameters:
PC_W, 12, program counter / program address width
INSTR_W, 16, program word width; opcode is always the top 4 bits, address field is the low PC_W bits, operand is the low 4 bits

Ports:
clk  in  1  system clock, rising edge
reset_n  in  1  asynchronous active-low reset
run  in  1  1 = sequencer advances; 0 = all state frozen
prog_addr  out  PC_W  program memory address, equals pc
prog_data  in  INSTR_W  program word; combinational read of prog_addr, valid in the same cycle
load_pc  in  1  decoder strobe: jump, PC <= address field (execute phase only)
inc_pc  in  1  decoder strobe: PC <= PC+1 (execute phase only)
load_flag  in  1  decoder strobe: capture alu_c/alu_z (execute phase only)
alu_c  in  1  ALU carry out
alu_z  in  1  ALU zero result
phase  out  1  0 = fetch, 1 = execute
opcode  out  4  IR[INSTR_W-1 -: 4], to decoder i
operand  out  4  IR[3:0], immediate nibble to datapath
address  out  PC_W  IR[PC_W-1:0], jump/memory target
c_flag  out  1  registered carry, to decoder C
z_flag  out  1  registered zero, to decoder Z
pc  out  PC_W  current program counter

Behaviour:
- Clock clk; reset_n is asynchronous and active-low. Assertion clears immediately: pc=0, IR=0 (opcode=0, operand=0, address=0), phase=0, c_flag=0, z_flag=0. Release takes effect on the next rising edge. Reset mid-execute discards pending strobes.
- FSM, 2 states, held in the phase register: FETCH(0) -> EXECUTE(1) -> FETCH, one transition per clk edge with run=1. With run=0 no register changes, including phase.
- FETCH cycle, run=1: IR <= prog_data (word at pc). pc, flags unchanged. load_pc/inc_pc/load_flag are ignored.
- EXECUTE cycle, run=1: opcode/operand/address are stable from IR.
  - PC update: load_pc=1 gives pc <= address (load wins if inc_pc is also 1). Else inc_pc=1 gives pc <= pc+1, mod 2^PC_W, so pc=4095 wraps to 0. Else pc holds.
  - load_flag=1: c_flag <= alu_c, z_flag <= alu_z. Otherwise both hold.
  - IR holds.
- Instruction latency: 2 cycles per instruction. A word presented at pc in FETCH is decoded in the following EXECUTE cycle. The new pc is visible in the next FETCH.
- prog_addr is pc combinationally; no registered output path.
- Flag and PC updates in the same EXECUTE edge are independent. A conditional jump uses c_flag/z_flag values from before that edge.
- No X on outputs after reset. Unused IR bits between opcode and address field are ignored.

Decomposition:
- Package nibbler_pkg:
  - OPC_W=4
  - typedef phase_t (PH_FETCH=0, PH_EXEC=1)
  - opcode enum, shared with the decoder (JC=0, JNC, CMPI, CMPM, LIT, IN, LD, ST, JZ, JNZ, ADDI, ADDM, JMP, OUT, NORI, NORM=15)
- One natural sub-module: nibbler_pc (PC register with load/inc/hold and wrap). Everything else lives in nibbler_fetch.

Test Plan:
- Reset: drive reset_n=0 mid-EXECUTE with pc=0x123, c_flag=1 -> all outputs 0 immediately, before any clk edge. First edge after release latches prog_data[0] into IR.
- Sequential run: ROM words 0xA005 at 0 and 0x4003 at 1, decoder strobe inc_pc=1 -> phase toggles 0,1,0,1. opcode=0xA, operand=5, then opcode=4, operand=3. pc goes 0,0,1,1,2.
- Jump priority: IR=0xC7FF in EXECUTE with load_pc=1 and inc_pc=1 -> pc=0x7FF, not pc+1. Strobes pulsed during FETCH leave pc unchanged.
- Wrap: pc=0xFFF, inc_pc=1 in EXECUTE -> pc=0x000. phase=0.
- Flags: EXECUTE with load_flag=1, alu_c=1, alu_z=0 -> c_flag=1, z_flag=0. Same inputs with load_flag=0 -> flags hold. load_flag in FETCH is ignored.
- Stall: run=0 for 5 cycles in EXECUTE with strobes active -> pc, IR, phase and flags unchanged. Resuming run=1 applies the strobes on the first edge.
